// File: rtl/pll_reconfig_target.sv
// PLL reconfiguration responder: shadow/active M/N counter banks, serial scan-out on reconfigure.
// Optional readback path enabled by defining PLL_RECONFIG_READBACK_EN.
module pll_reconfig_target #(
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned WRITE_LAT   = 2,
  parameter int unsigned TAIL_CYCLES = 4
) (
  input  logic              clock_ctr,
  input  logic              sys_reset,
  input  logic [3:0]        counter_type,
  input  logic [2:0]        counter_param,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_param,
  input  logic              read_param,
  input  logic              reconfig,
  input  logic              reset,
  input  logic              pll_areset_in,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              pll_areset,
  output logic              scandata,
  output logic              scanclk_en,
  output logic [DATA_W-1:0] n_high,
  output logic [DATA_W-1:0] n_low,
  output logic [DATA_W-1:0] m_high,
  output logic [DATA_W-1:0] m_low,
  output logic              cfg_valid,
  output logic              cmd_error
);

  localparam int unsigned ScanLen = 4 * DATA_W;
  localparam int unsigned MaxA    = (ScanLen > WRITE_LAT) ? ScanLen : WRITE_LAT;
  localparam int unsigned MaxLen  = (MaxA > TAIL_CYCLES) ? MaxA : TAIL_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0] WrLast   = CntW'(WRITE_LAT - 1);
  localparam logic [CntW-1:0] ScanLast = CntW'(ScanLen - 1);
  localparam logic [CntW-1:0] TailLast = CntW'(TAIL_CYCLES - 1);

  // Bank index: {type[0], param[0]} -> 0 n_high, 1 n_low, 2 m_high, 3 m_low.
  localparam int unsigned IdxNHigh = 0;
  localparam int unsigned IdxNLow  = 1;
  localparam int unsigned IdxMHigh = 2;
  localparam int unsigned IdxMLow  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StScan,
    StUpd,
    StTail
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     wr_hist_q, wr_hist_d;
  logic                     rc_hist_q, rc_hist_d;
  logic [3:0]               type_q, type_d;
  logic [2:0]               param_q, param_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [3:0][DATA_W-1:0]   shadow_q, shadow_d;
  logic [3:0][DATA_W-1:0]   active_q, active_d;
  logic [ScanLen-1:0]       shift_q, shift_d;
  logic                     cfg_valid_q, cfg_valid_d;
  logic                     cmd_error_q, cmd_error_d;
  logic                     pll_areset_q;

  logic                     wr_new, rd_new, rc_new;
  logic                     addr_ok;
  logic [1:0]               addr_idx;

`ifdef PLL_RECONFIG_READBACK_EN
  logic                     rd_hist_q, rd_hist_d;
  logic [DATA_W-1:0]        data_out_q, data_out_d;

  assign rd_new   = read_param & ~rd_hist_q;
  assign data_out = data_out_q;
`else
  logic unused_read;

  assign unused_read = read_param;
  assign rd_new      = 1'b0;
  assign data_out    = '0;
`endif

  assign wr_new   = write_param & ~wr_hist_q;
  assign rc_new   = reconfig & ~rc_hist_q;

  assign addr_ok  = (type_q[3:1] == 3'b000) && (param_q[2:1] == 2'b00);
  assign addr_idx = {type_q[0], param_q[0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_hist_d   = write_param;
    rc_hist_d   = reconfig;
    type_d      = type_q;
    param_d     = param_q;
    wdata_d     = wdata_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    shift_d     = shift_q;
    cfg_valid_d = cfg_valid_q;
    cmd_error_d = cmd_error_q;
`ifdef PLL_RECONFIG_READBACK_EN
    rd_hist_d   = read_param;
    data_out_d  = data_out_q;
`endif

    if (reset) begin
      state_d     = StIdle;
      cnt_d       = '0;
      shadow_d    = '0;
      cmd_error_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (rc_new) begin
            state_d = StScan;
            shift_d = {shadow_q[IdxMHigh], shadow_q[IdxMLow],
                       shadow_q[IdxNHigh], shadow_q[IdxNLow]};
          end else if (wr_new) begin
            state_d = StWr;
            type_d  = counter_type;
            param_d = counter_param;
            wdata_d = data_in;
          end else if (rd_new) begin
            state_d = StRd;
            type_d  = counter_type;
            param_d = counter_param;
          end
        end
        StWr: begin
          if (cnt_q == WrLast) begin
            state_d = StIdle;
            if (addr_ok) begin
              shadow_d[addr_idx] = wdata_q;
            end else begin
              cmd_error_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRd: begin
          if (cnt_q == WrLast) begin
            state_d = StIdle;
`ifdef PLL_RECONFIG_READBACK_EN
            if (addr_ok) begin
              data_out_d = shadow_q[addr_idx];
            end else begin
              data_out_d  = '0;
              cmd_error_d = 1'b1;
            end
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StScan: begin
          shift_d = {shift_q[ScanLen-2:0], 1'b0};
          if (cnt_q == ScanLast) begin
            state_d = StUpd;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StUpd: begin
          active_d    = shadow_q;
          cfg_valid_d = 1'b1;
          state_d     = StTail;
          cnt_d       = '0;
        end
        StTail: begin
          if (cnt_q == TailLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // History flops reset to 1 so a command held high through reset does not fire.
  always_ff @(posedge clock_ctr or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_hist_q   <= 1'b1;
      rc_hist_q   <= 1'b1;
      type_q      <= '0;
      param_q     <= '0;
      wdata_q     <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      shift_q     <= '0;
      cfg_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_hist_q   <= wr_hist_d;
      rc_hist_q   <= rc_hist_d;
      type_q      <= type_d;
      param_q     <= param_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      shift_q     <= shift_d;
      cfg_valid_q <= cfg_valid_d;
      cmd_error_q <= cmd_error_d;
    end
  end

`ifdef PLL_RECONFIG_READBACK_EN
  always_ff @(posedge clock_ctr or posedge sys_reset) begin
    if (sys_reset) begin
      rd_hist_q  <= 1'b1;
      data_out_q <= '0;
    end else begin
      rd_hist_q  <= rd_hist_d;
      data_out_q <= data_out_d;
    end
  end
`endif

  always_ff @(posedge clock_ctr or posedge sys_reset) begin
    if (sys_reset) begin
      pll_areset_q <= 1'b0;
    end else begin
      pll_areset_q <= pll_areset_in;
    end
  end

  assign busy       = (state_q != StIdle);
  assign scanclk_en = (state_q == StScan);
  assign scandata   = scanclk_en & shift_q[ScanLen-1];
  assign pll_areset = pll_areset_q;
  assign n_high     = active_q[IdxNHigh];
  assign n_low      = active_q[IdxNLow];
  assign m_high     = active_q[IdxMHigh];
  assign m_low      = active_q[IdxMLow];
  assign cfg_valid  = cfg_valid_q;
  assign cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_pll_reconfig_target.sv
// Directed bench for pll_reconfig_target: write/read/reconfigure, held levels, invalid addresses,
// soft-reset abort. Readback checks follow PLL_RECONFIG_READBACK_EN.
module tb_pll_reconfig_target;
  localparam int unsigned DW = 9;

  logic          clock_ctr = 1'b0;
  logic          sys_reset;
  logic [3:0]    counter_type;
  logic [2:0]    counter_param;
  logic [DW-1:0] data_in;
  logic          write_param, read_param, reconfig, reset, pll_areset_in;
  logic          busy, pll_areset, scandata, scanclk_en, cfg_valid, cmd_error;
  logic [DW-1:0] data_out, n_high, n_low, m_high, m_low;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock_ctr = ~clock_ctr;

  pll_reconfig_target #(
    .DATA_W      (DW),
    .WRITE_LAT   (2),
    .TAIL_CYCLES (4)
  ) u_dut (
    .clock_ctr     (clock_ctr),
    .sys_reset     (sys_reset),
    .counter_type  (counter_type),
    .counter_param (counter_param),
    .data_in       (data_in),
    .write_param   (write_param),
    .read_param    (read_param),
    .reconfig      (reconfig),
    .reset         (reset),
    .pll_areset_in (pll_areset_in),
    .busy          (busy),
    .data_out      (data_out),
    .pll_areset    (pll_areset),
    .scandata      (scandata),
    .scanclk_en    (scanclk_en),
    .n_high        (n_high),
    .n_low         (n_low),
    .m_high        (m_high),
    .m_low         (m_low),
    .cfg_valid     (cfg_valid),
    .cmd_error     (cmd_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Counts busy cycles from the negedge after a command is driven; bounded.
  task automatic run_busy(output int busy_n, output int scan_n, output logic [63:0] bits,
                          output int stray);
    busy_n = 0;
    scan_n = 0;
    bits   = '0;
    stray  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_ctr);
      if (scanclk_en) begin
        scan_n++;
        bits = {bits[62:0], scandata};
      end else if (scandata) begin
        stray++;
      end
      if (!busy) break;
      busy_n++;
    end
  endtask

  task automatic do_write(input logic [3:0] t, input logic [2:0] p, input logic [DW-1:0] d,
                          output int b);
    int s, st;
    logic [63:0] bits;
    @(negedge clock_ctr);
    counter_type  = t;
    counter_param = p;
    data_in       = d;
    write_param   = 1'b1;
    run_busy(b, s, bits, st);
    write_param   = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] t, input logic [2:0] p, output int b);
    int s, st;
    logic [63:0] bits;
    @(negedge clock_ctr);
    counter_type  = t;
    counter_param = p;
    read_param    = 1'b1;
    run_busy(b, s, bits, st);
    read_param    = 1'b0;
  endtask

  task automatic do_reconfig(output int b, output int s, output logic [63:0] bits,
                             output int st);
    @(negedge clock_ctr);
    reconfig = 1'b1;
    run_busy(b, s, bits, st);
    reconfig = 1'b0;
  endtask

  initial begin
    int b, s, st;
    logic [63:0] bits;
    logic [63:0] exp_bits;

    sys_reset     = 1'b1;
    counter_type  = '0;
    counter_param = '0;
    data_in       = '0;
    write_param   = 1'b1;
    read_param    = 1'b1;
    reconfig      = 1'b1;
    reset         = 1'b0;
    pll_areset_in = 1'b0;

    // Reset release with commands held high: nothing may fire.
    repeat (2) @(negedge clock_ctr);
    check("busy_in_reset", busy, 1'b0);
    sys_reset = 1'b0;
    repeat (3) @(negedge clock_ctr);
    check("rst_busy", busy, 1'b0);
    check("rst_scanclk_en", scanclk_en, 1'b0);
    check("rst_scandata", scandata, 1'b0);
    check("rst_banks", {m_high, m_low, n_high, n_low}, 36'h0);
    check("rst_data_out", data_out, '0);
    check("rst_cfg_valid", cfg_valid, 1'b0);
    check("rst_cmd_error", cmd_error, 1'b0);
    check("rst_pll_areset", pll_areset, 1'b0);
    write_param = 1'b0;
    read_param  = 1'b0;
    reconfig    = 1'b0;

    // pll_areset: one-cycle registered copy.
    pll_areset_in = 1'b1;
    @(negedge clock_ctr);
    check("areset_rise", pll_areset, 1'b1);
    pll_areset_in = 1'b0;
    @(negedge clock_ctr);
    check("areset_fall", pll_areset, 1'b0);

    // Write M high = 12.
    do_write(4'b0001, 3'b000, 9'h00C, b);
    check("wr_busy_cycles", b, 2);
    check("wr_m_high_not_active", m_high, 9'h000);
`ifdef PLL_RECONFIG_READBACK_EN
    do_read(4'b0001, 3'b000, b);
    check("rd_busy_cycles", b, 2);
    check("rd_m_high", data_out, 9'h00C);
    do_read(4'b0000, 3'b011, b);
    check("rd_bad_data", data_out, 9'h000);
    check("rd_bad_err", cmd_error, 1'b1);
    reset = 1'b1;
    @(negedge clock_ctr);
    reset = 1'b0;
    check("rd_bad_err_clr", cmd_error, 1'b0);
    do_write(4'b0001, 3'b000, 9'h00C, b);
`else
    do_read(4'b0001, 3'b000, b);
    check("rd_ignored_busy", b, 0);
    check("rd_ignored_data", data_out, 9'h000);
    check("rd_ignored_err", cmd_error, 1'b0);
`endif

    // Full reconfigure: M 12/12, N 2/2.
    do_write(4'b0001, 3'b001, 9'h00C, b);
    do_write(4'b0000, 3'b000, 9'h002, b);
    do_write(4'b0000, 3'b001, 9'h002, b);
    check("wr_n_low_busy", b, 2);
    do_reconfig(b, s, bits, st);
    exp_bits = {28'h0, 9'h00C, 9'h00C, 9'h002, 9'h002};
    check("rc_busy_cycles", b, 41);
    check("rc_scan_cycles", s, 36);
    check("rc_scan_bits", bits, exp_bits);
    check("rc_scandata_idle", st, 0);
    check("rc_m_high", m_high, 9'h00C);
    check("rc_m_low", m_low, 9'h00C);
    check("rc_n_high", n_high, 9'h002);
    check("rc_n_low", n_low, 9'h002);
    check("rc_cfg_valid", cfg_valid, 1'b1);

    // write_param held for 10 cycles: one write only.
    @(negedge clock_ctr);
    counter_type  = 4'b0001;
    counter_param = 3'b000;
    data_in       = 9'h005;
    write_param   = 1'b1;
    b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock_ctr);
      if (busy) b++;
      if (i == 9) write_param = 1'b0;
    end
    check("held_wr_busy", b, 2);

    // Reconfig edge while busy is dropped; still-high level must not fire later.
    @(negedge clock_ctr);
    counter_type  = 4'b0000;
    counter_param = 3'b000;
    data_in       = 9'h003;
    write_param   = 1'b1;
    @(negedge clock_ctr);
    check("drop_busy_first", busy, 1'b1);
    reconfig = 1'b1;
    run_busy(b, s, bits, st);
    check("drop_busy_cycles", b, 1);
    write_param = 1'b0;
    repeat (3) @(negedge clock_ctr);
    check("drop_no_reconfig", busy, 1'b0);
    reconfig = 1'b0;

    // Invalid addresses: error flag, shadow untouched, WR timing kept.
    do_write(4'b0100, 3'b000, 9'h1FF, b);
    check("inv_type_busy", b, 2);
    check("inv_type_err", cmd_error, 1'b1);
    do_write(4'b0001, 3'b010, 9'h077, b);
    check("inv_param_err", cmd_error, 1'b1);
    do_reconfig(b, s, bits, st);
    check("inv_banks", {m_high, m_low, n_high, n_low}, {9'h005, 9'h00C, 9'h003, 9'h002});
    check("inv_err_sticky", cmd_error, 1'b1);
    @(negedge clock_ctr);
    reset = 1'b1;
    @(negedge clock_ctr);
    reset = 1'b0;
    check("srst_err_clr", cmd_error, 1'b0);
    check("srst_keeps_active", m_high, 9'h005);

    // Abort mid-scan at scan cycle 10.
    do_write(4'b0001, 3'b000, 9'h1AB, b);
    @(negedge clock_ctr);
    reconfig = 1'b1;
    repeat (11) @(negedge clock_ctr);
    check("abort_in_scan", scanclk_en, 1'b1);
    reset    = 1'b1;
    reconfig = 1'b0;
    @(negedge clock_ctr);
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_scanclk_en", scanclk_en, 1'b0);
    check("abort_scandata", scandata, 1'b0);
    repeat (45) @(negedge clock_ctr);
    check("abort_no_upd", m_high, 9'h005);
    check("abort_cfg_valid", cfg_valid, 1'b1);
    check("abort_idle", busy, 1'b0);

    // Soft reset cleared the shadow bank.
    do_reconfig(b, s, bits, st);
    check("zero_rc_busy", b, 41);
    check("zero_rc_bits", bits, 64'h0);
    check("zero_banks", {m_high, m_low, n_high, n_low}, 36'h0);
`ifndef PLL_RECONFIG_READBACK_EN
    check("final_data_out", data_out, 9'h000);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
